// File: rtl/tt6581_pkg.sv
// Shared types and helpers for the audio path.
//   AUDIO_W       : output sample width (14, signed)
//   VOICE_W       : voice sample width (12, signed)
//   mixer_state_t : mixer frame FSM states
//   sat14()       : clamp a 20-bit signed value to [-8192, 8191]
package tt6581_pkg;
  localparam int AUDIO_W = 14;
  localparam int VOICE_W = 12;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SCALE, DCB, OUT} mixer_state_t;

  function automatic logic signed [AUDIO_W-1:0] sat14(input logic signed [19:0] v);
    if (v > 20'sd8191)       return 14'h1FFF;
    else if (v < -20'sd8192) return 14'h2000;
    else                     return v[AUDIO_W-1:0];
  endfunction
endpackage

// File: rtl/audio_mixer_dc_blocker.sv
// dc_blocker: first-order DC-blocking filter, advanced once per en_i strobe.
//   y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), 20-bit signed state.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (clears state)
//   en_i          : advance the filter by one sample
//   x_i           : input sample (14-bit signed)
//   y_o           : saturated next output, valid in the en_i cycle
module dc_blocker
  import tt6581_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic signed [AUDIO_W-1:0] x_i,
  output logic signed [AUDIO_W-1:0] y_o
);
  logic signed [19:0] x_ext, x_prev_q, y_q, y_next;

  // Explicit sign extension keeps every operand signed so >>> stays arithmetic.
  assign x_ext  = {{(20-AUDIO_W){x_i[AUDIO_W-1]}}, x_i};
  assign y_next = x_ext - x_prev_q + y_q - (y_q >>> 8);
  // Output is clamped; the state keeps the unsaturated value.
  assign y_o    = sat14(y_next);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_prev_q <= '0;
      y_q      <= '0;
    end else if (en_i) begin
      x_prev_q <= x_ext;
      y_q      <= y_next;
    end
  end
endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: sample-rate tick, time-multiplexed voice fetch, mute-aware sum,
// 4-bit master volume via 4-cycle shift-add, 14-bit saturation, valid strobe.
// Optional DC-blocking stage compiled in with AUDIO_MIXER_DC_BLOCK_EN.
// Ports:
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   voice_sel_o/voice_req_o : voice index and one-cycle request strobe
//   voice_valid_i/data_i    : response for the requested voice (sampled in WAIT)
//   voice_mute_i            : per-voice mute, latched at the tick
//   volume_i                : master gain value/8, latched at the tick
//   audio_o/audio_valid_o   : mixed sample and its one-cycle strobe
//   overrun_o               : sticky, tick arrived mid-frame
module audio_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic [$clog2(NUM_VOICES)-1:0] voice_sel_o,
  output logic                          voice_req_o,
  input  logic                          voice_valid_i,
  input  logic signed [VOICE_W-1:0]     voice_data_i,
  input  logic [NUM_VOICES-1:0]         voice_mute_i,
  input  logic [3:0]                    volume_i,
  output logic signed [13:0]            audio_o,
  output logic                          audio_valid_o,
  output logic                          overrun_o
);
  import tt6581_pkg::*;

  localparam int SEL_W = $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [SEL_W-1:0] LAST_K   = SEL_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(SAMPLE_DIV - 1);

  mixer_state_t              state;
  logic [CNT_W-1:0]          cnt;
  logic                      tick;
  logic [SEL_W-1:0]          k;
  logic [3:0]                vol_q;
  logic [NUM_VOICES-1:0]     mute_q;
  logic [1:0]                scl_i;
  logic signed [AUDIO_W-1:0] acc, data_ext, voice_add;
  logic signed [17:0]        product, acc_ext, addend, prod_next;
  logic signed [19:0]        prod_ext;
  logic signed [AUDIO_W-1:0] scaled;

  assign tick        = (cnt == TICK_CNT);
  assign voice_sel_o = k;

  always_comb begin
    data_ext  = {{(AUDIO_W-VOICE_W){voice_data_i[VOICE_W-1]}}, voice_data_i};
    voice_add = mute_q[k] ? '0 : data_ext;
    acc_ext   = {{(18-AUDIO_W){acc[AUDIO_W-1]}}, acc};
    addend    = vol_q[scl_i] ? (acc_ext <<< scl_i) : '0;
    prod_next = product + addend;
    prod_ext  = {{2{prod_next[17]}}, prod_next};
    scaled    = sat14(prod_ext >>> 3);
  end

`ifdef AUDIO_MIXER_DC_BLOCK_EN
  logic signed [AUDIO_W-1:0] dc_x_q, dc_y;

  dc_blocker u_dc_blocker (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state == DCB),
    .x_i    (dc_x_q),
    .y_o    (dc_y)
  );
`endif

  // Outputs are set on the transition into their state, so req is high
  // during REQ and audio_valid_o during OUT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      k             <= '0;
      vol_q         <= '0;
      mute_q        <= '0;
      scl_i         <= '0;
      acc           <= '0;
      product       <= '0;
      voice_req_o   <= 1'b0;
      audio_o       <= '0;
      audio_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
      dc_x_q        <= '0;
`endif
    end else begin
      cnt           <= tick ? '0 : cnt + 1'b1;
      voice_req_o   <= 1'b0;
      audio_valid_o <= 1'b0;
      if (tick && state != IDLE) overrun_o <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          vol_q       <= volume_i;
          mute_q      <= voice_mute_i;
          acc         <= '0;
          product     <= '0;
          k           <= '0;
          voice_req_o <= 1'b1;
          state       <= REQ;
        end
        REQ: state <= WAIT;
        WAIT: if (voice_valid_i) begin
          acc <= acc + voice_add;
          if (k == LAST_K) begin
            scl_i <= '0;
            state <= SCALE;
          end else begin
            k           <= k + 1'b1;
            voice_req_o <= 1'b1;
            state       <= REQ;
          end
        end
        SCALE: begin
          product <= prod_next;
          scl_i   <= scl_i + 1'b1;
          if (scl_i == 2'd3) begin
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            dc_x_q <= scaled;
            state  <= DCB;
`else
            audio_o       <= scaled;
            audio_valid_o <= 1'b1;
            state         <= OUT;
`endif
          end
        end
`ifdef AUDIO_MIXER_DC_BLOCK_EN
        DCB: begin
          audio_o       <= dc_y;
          audio_valid_o <= 1'b1;
          state         <= OUT;
        end
`endif
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_mixer.sv
module tb_audio_mixer;
  localparam int NV  = 3;
  localparam int VW  = 12;
  localparam int DIV = 20;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
  localparam int DC = 1;
`else
  localparam int DC = 0;
`endif

  logic                   clk_i, rst_ni;
  logic [1:0]             voice_sel_o;
  logic                   voice_req_o, voice_valid_i;
  logic signed [VW-1:0]   voice_data_i;
  logic [NV-1:0]          voice_mute_i;
  logic [3:0]             volume_i;
  logic signed [13:0]     audio_o;
  logic                   audio_valid_o, overrun_o;

  audio_mixer #(.NUM_VOICES(NV), .VOICE_W(VW), .SAMPLE_DIV(DIV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .voice_sel_o(voice_sel_o), .voice_req_o(voice_req_o),
    .voice_valid_i(voice_valid_i), .voice_data_i(voice_data_i), .voice_mute_i(voice_mute_i),
    .volume_i(volume_i), .audio_o(audio_o), .audio_valid_o(audio_valid_o), .overrun_o(overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;
  int vv[NV];
  bit stall_v1 = 1'b0;

  typedef struct { int val; bit lat; } exp_t;
  exp_t q[$];

  // Reference model state (DC filter history)
  int y_m = 0;
  int xp_m = 0;

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int clamp(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int model_frame(input int vol, input int mute);
    int s, x;
    s = 0;
    for (int i = 0; i < NV; i++) if (!mute[i]) s += vv[i];
    x = clamp(fdiv(s * vol, 8));
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    begin
      int y;
      y = x - xp_m + y_m - fdiv(y_m, 256);
      xp_m = x;
      y_m = y;
      return clamp(y);
    end
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Voice responder: valid pulses one cycle after each request (26 when stalling voice 1)
  initial begin
    int cnt, s;
    cnt = 0;
    s = 0;
    voice_valid_i = 1'b0;
    voice_data_i  = '0;
    forever begin
      @(negedge clk_i);
      voice_valid_i = 1'b0;
      if (!rst_ni) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          voice_valid_i = 1'b1;
          voice_data_i  = VW'(vv[s]);
        end
      end
      if (voice_req_o) begin
        s   = int'(voice_sel_o);
        cnt = (stall_v1 && s == 1) ? 26 : 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output strobe
  initial begin
    int nreq, freq;
    logic signed [13:0] last;
    exp_t e;
    nreq = 0;
    freq = 0;
    last = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        nreq = 0;
        last = '0;
        continue;
      end
      if (voice_req_o) begin
        if (nreq == 0) freq = cyc;
        nreq++;
      end
      if (audio_valid_o) begin
        out_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%0d expected=none", audio_o);
        end else begin
          e = q.pop_front();
          if (audio_o != e.val) begin
            errors++;
            $display("FAIL audio_o got=%0d expected=%0d", audio_o, e.val);
          end
          if (e.lat) begin
            chk("req_count", nreq, NV);
            chk("req_to_valid", cyc - freq, 10 + DC);
          end
        end
        last = audio_o;
        nreq = 0;
      end else begin
        checks++;
        if (audio_o !== last) begin
          errors++;
          $display("FAIL audio_hold got=%0d expected=%0d", audio_o, last);
        end
      end
    end
  end

  task automatic wait_out();
    int start, n;
    start = out_cnt;
    n = 0;
    while (out_cnt == start && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (out_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL output_timeout got=none expected=strobe");
    end
  endtask

  task automatic run_frame_exp(input int a, input int b, input int c, input int vol,
                               input int mute, input bit lat, input int expv);
    exp_t e;
    vv[0] = a; vv[1] = b; vv[2] = c;
    volume_i = vol[3:0];
    voice_mute_i = mute[NV-1:0];
    e.val = expv;
    e.lat = lat;
    q.push_back(e);
    wait_out();
  endtask

  task automatic run_frame(input int a, input int b, input int c, input int vol,
                           input int mute, input bit lat);
    int m;
    vv[0] = a; vv[1] = b; vv[2] = c;
    m = model_frame(vol, mute);
    run_frame_exp(a, b, c, vol, mute, lat, m);
  endtask

  initial begin
    int fr, fv;
    exp_t e;
    rst_ni = 1'b0;
    volume_i = 4'd8;
    voice_mute_i = '0;
    vv[0] = 100; vv[1] = 200; vv[2] = 300;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_audio_o", audio_o, 0);
    chk("rst_audio_valid", audio_valid_o, 0);
    chk("rst_voice_req", voice_req_o, 0);
    chk("rst_voice_sel", voice_sel_o, 0);
    chk("rst_overrun", overrun_o, 0);

    e.val = model_frame(8, 0);
    e.lat = 1'b1;
    q.push_back(e);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    fr = -1;
    fv = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (voice_req_o && fr < 0) fr = c;
      if (audio_valid_o && fv < 0) begin
        fv = c;
        break;
      end
    end
    chk("first_req_cycle", fr, 20);
    chk("first_valid_cycle", fv, 30 + DC);
    @(negedge clk_i);

    run_frame(-100, -200, -300, 8, 0, 1);
    run_frame(2047, 2047, 2047, 15, 0, 1);
    run_frame(-2048, -2048, -2048, 15, 0, 1);
    run_frame(1234, -567, 890, 0, 0, 1);
    run_frame(100, 200, 300, 8, 3'b010, 1);
    chk("overrun_clear", overrun_o, 0);

    for (int i = 0; i < 20; i++)
      run_frame(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 7)), 1);

    stall_v1 = 1'b1;
    run_frame(100, 200, 300, 8, 0, 0);
    stall_v1 = 1'b0;
    chk("overrun_after_stall", overrun_o, 1);
    run_frame(int'($urandom_range(0, 4095)) - 2048, 17, -33, int'($urandom_range(0, 15)), 0, 1);
    run_frame(500, -250, 125, 12, 3'b100, 1);
    chk("overrun_sticky", overrun_o, 1);

    // Second reset clears overrun and filter history
    @(negedge clk_i);
    rst_ni = 1'b0;
    y_m = 0;
    xp_m = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst2_overrun", overrun_o, 0);
    chk("rst2_audio_o", audio_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    run_frame_exp(100, 400, 500, 8, 0, 1, 1000);
    run_frame_exp(100, 400, 500, 8, 0, 1, DC ? 997 : 1000);
    run_frame_exp(100, 400, 500, 8, 0, 1, DC ? 994 : 1000);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/audio_mixer.md
# audio_mixer

Upstream stage of the delta-sigma DAC. Generates the audio sample-rate tick, fetches one signed sample from each voice over a time-multiplexed request/valid bus, and sums the unmuted voices. It then applies a 4-bit master volume with a sequential shift-add multiply, saturates the result to 14 bits, and emits it with a one-cycle valid strobe that drives the DAC's sample/hold input.

## Interface
- `NUM_VOICES`, default 3: number of voices mixed.
- `VOICE_W`, default 12: signed voice sample width.
- `SAMPLE_DIV`, default 1000: `clk_i` cycles per output sample (50 MHz / 50 kHz).
- `clk_i` input 1: system clock, 50 MHz.
- `rst_ni` input 1: reset, synchronous, active-low.
- `voice_sel_o` output `$clog2(NUM_VOICES)`: index of the voice being requested.
- `voice_req_o` output 1: one-cycle request strobe for voice `voice_sel_o`.
- `voice_valid_i` input 1: `voice_data_i` is valid for the requested voice.
- `voice_data_i` input `VOICE_W`, signed: voice sample.
- `voice_mute_i` input `NUM_VOICES`: per-voice mute, 1 = contributes 0.
- `volume_i` input 4: master gain, value/8 (8 = unity, 15 = 1.875).
- `audio_o` output 14, signed: mixed sample, held between strobes.
- `audio_valid_o` output 1: one-cycle strobe, new `audio_o`.
- `overrun_o` output 1: sticky; a tick arrived while a frame was still in progress.

## Operation
- Tick counter counts 0..`SAMPLE_DIV`-1 and wraps. The tick is the cycle in which count == `SAMPLE_DIV`-1.
- FSM states:
  - **IDLE**: on tick, latch `volume_i` and `voice_mute_i`, clear the 14-bit accumulator, set voice index k=0, go to REQ.
  - **REQ**: drive `voice_sel_o`=k and `voice_req_o`=1 for one cycle, then go to WAIT.
  - **WAIT**: stay until `voice_valid_i`=1. On valid, add `voice_data_i` (sign-extended) to the accumulator, or add 0 if voice k is muted. If k < `NUM_VOICES`-1, increment k and go to REQ; otherwise go to SCALE.
  - **SCALE**: 4 cycles, i=0..3. If volume bit i is set, add accumulator<<i to an 18-bit signed product. Then go to DCB when the DC block is configured, otherwise to OUT.
  - **DCB**: 1 cycle, DC-blocking filter (see Configuration). Go to OUT.
  - **OUT**: register the result into `audio_o` and pulse `audio_valid_o`. Go to IDLE.
- Arithmetic:
  - Result = product >>> 3, saturated to [-8192, 8191].
  - 3×12-bit sum never overflows the 14-bit accumulator.
- Muted voices are still requested, so frame timing is independent of mute state.
- `voice_valid_i` is ignored outside WAIT.
- A tick while not in IDLE sets `overrun_o` and is dropped; the current frame continues. `overrun_o` clears only on reset.
- A WAIT that never receives valid stalls the frame indefinitely; every subsequent tick counts as an overrun.
- Volume 0 produces 0 regardless of voice data.

## Timing
- Reset values: `audio_o`=0, `audio_valid_o`=0, `voice_req_o`=0, `voice_sel_o`=0, `overrun_o`=0. FSM returns to IDLE, tick counter to 0, DC state to 0. A reset mid-frame abandons the frame with no strobe.
- First tick is at cycle `SAMPLE_DIV`-1 after reset release.
- With `voice_valid_i` returned in the cycle after each request, `audio_valid_o` asserts 2·`NUM_VOICES`+5 cycles after the tick cycle: 11 at default, 12 with the DC block.
- `audio_o` changes only in the `audio_valid_o` cycle.
- `SAMPLE_DIV` must exceed the frame latency.

## Configuration
- `AUDIO_MIXER_DC_BLOCK_EN` defined:
  - DCB state compiled in.
  - y[n] = x[n] − x[n−1] + y[n−1] − (y[n−1] >>> 8), with 20-bit signed state. x[n] is the saturated scaled sample.
  - y[n] is saturated to 14 bits for output; the unsaturated state is retained.
  - Latency is +1 cycle.
- Undefined: DCB state and filter registers are absent; the scaled sample goes straight to OUT.

## Structure
- Shared package `tt6581_pkg`: `AUDIO_W`=14, `VOICE_W`=12, `mixer_state_t` enum (IDLE, REQ, WAIT, SCALE, DCB, OUT), and saturation function `sat14`.
- One sub-module, `dc_blocker`: enable-strobed filter, instantiated only under `AUDIO_MIXER_DC_BLOCK_EN`.

## Test plan
All scenarios use `SAMPLE_DIV`=20 and a voice model that returns valid one cycle after each request.
- Reset, hold: all outputs 0. After release, `voice_req_o` first at cycle 20 and `audio_valid_o` at cycle 30 (31 with the DC block).
- Voices 100/200/300, volume 8, no mute -> `audio_o`=600. Voices −100/−200/−300 -> −600.
- Saturation: voices 2047×3, volume 15 -> 8191. Voices −2048×3, volume 15 -> −8192. Volume 0 -> 0.
- Mute: voices 100/200/300, mute=3'b010, volume 8 -> 400. Requests are still issued for all three voices and latency is unchanged.
- Stall: hold `voice_valid_i` low for 25 cycles on voice 1 -> `overrun_o`=1 at the next tick, which is dropped. The frame completes once valid returns, and `overrun_o` stays 1 until reset.
- With `AUDIO_MIXER_DC_BLOCK_EN`: constant sum 1000, volume 8 -> successive outputs 1000, 997, 994, … decaying toward 0.
